mux_tree_pipe: RTL and testbench

Parametrised, optionally pipelined N-way mux tree for the forwarding arbiter of the parallel BPF cores. It selects one source's data word and valid flag by a binary select and carries the select index alongside the data. Each tree level can be registered to close timing on wide or deep trees. It generalises the 2:1 mux_tree_node: arbitrary input count, configurable pipelining, a stall control, and out-of-range select detection.

---
 rtl/mux_tree_pipe.sv | 136 +++++++++++++
 tb/tb_mux_tree_pipe.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_tree_pipe.sv
// Purpose: N-way binary mux tree selecting one source word, its valid and the select index.
// Latency: (PIPE_STRIDE == 0) ? 0 : floor(DEPTH / PIPE_STRIDE) cycles; a register follows every PIPE_STRIDE-th level.
// Backpressure: en = 0 freezes every stage register; a zero-latency tree ignores en.
//
// Ports:
//   clk, rst_n       clock (rising edge) and asynchronous active-low reset
//   en               pipeline advance; 0 holds all stage registers
//   in_data          N_INPUTS packed source words; source k at [k*DATA_WIDTH +: DATA_WIDTH]
//   in_valid         per-source valid
//   sel, sel_valid   binary source index and its qualifier
//   out_data         selected word (passes through even when out_valid is 0)
//   out_valid        selected source valid, select valid and in range
//   out_sel          select value that produced out_data
//   out_err          sel_valid was set with sel >= N_INPUTS
module mux_tree_pipe #(
    parameter int N_INPUTS    = 8,
    parameter int DATA_WIDTH  = 64,
    parameter int PIPE_STRIDE = 1,
    parameter int SEL_WIDTH   = $clog2(N_INPUTS)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           en,
    input  logic [N_INPUTS*DATA_WIDTH-1:0] in_data,
    input  logic [N_INPUTS-1:0]            in_valid,
    input  logic [SEL_WIDTH-1:0]           sel,
    input  logic                           sel_valid,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic                           out_valid,
    output logic [SEL_WIDTH-1:0]           out_sel,
    output logic                           out_err
);

    localparam int DEPTH      = SEL_WIDTH;
    localparam int LEAVES     = 1 << DEPTH;
    // Guards the modulo below when the tree is fully combinational.
    localparam int STRIDE_DIV = (PIPE_STRIDE == 0) ? 1 : PIPE_STRIDE;

    // Range check is done once at the leaves and then travels with the word,
    // so it lines up with the data no matter how many stages are inserted.
    logic in_err;
    assign in_err = sel_valid & ({1'b0, sel} >= (SEL_WIDTH + 1)'(N_INPUTS));

    // Level 0 is the padded leaf row; level DEPTH is the root. Each level
    // exposes its (possibly registered) node outputs to the next level.
    // Select, sel_valid and err are common to every node of a level, so one
    // copy per level is kept. The full select is carried: it holds both the
    // bits still to be consumed downstream and the value reported on out_sel.
    for (genvar i = 0; i <= DEPTH; i++) begin : g_lvl
        localparam int NODES = LEAVES >> i;

        logic [NODES*DATA_WIDTH-1:0] dat;
        logic [NODES-1:0]            vld;
        logic [SEL_WIDTH-1:0]        sel_s;
        logic                        sv_s;
        logic                        err_s;

        if (i == 0) begin : g_leaf
            // Padded leaves carry data 0 and valid 0.
            if (LEAVES > N_INPUTS) begin : g_pad
                assign dat = {{((LEAVES - N_INPUTS) * DATA_WIDTH){1'b0}}, in_data};
                assign vld = {{(LEAVES - N_INPUTS){1'b0}}, in_valid};
            end else begin : g_nopad
                assign dat = in_data;
                assign vld = in_valid;
            end
            assign sel_s = sel;
            assign sv_s  = sel_valid;
            assign err_s = in_err;
        end else begin : g_node
            logic [NODES*DATA_WIDTH-1:0] dat_d;
            logic [NODES-1:0]            vld_d;

            // Node j of level i picks child 2j or 2j+1 of level i-1 with sel[i-1].
            always_comb begin
                dat_d = '0;
                vld_d = '0;
                for (int j = 0; j < NODES; j++) begin
                    if (g_lvl[i-1].sel_s[i-1]) begin
                        dat_d[j*DATA_WIDTH +: DATA_WIDTH] = g_lvl[i-1].dat[(2*j+1)*DATA_WIDTH +: DATA_WIDTH];
                        vld_d[j]                          = g_lvl[i-1].vld[2*j+1];
                    end else begin
                        dat_d[j*DATA_WIDTH +: DATA_WIDTH] = g_lvl[i-1].dat[(2*j)*DATA_WIDTH +: DATA_WIDTH];
                        vld_d[j]                          = g_lvl[i-1].vld[2*j];
                    end
                end
            end

            if ((PIPE_STRIDE != 0) && ((i % STRIDE_DIV) == 0)) begin : g_reg
                logic [NODES*DATA_WIDTH-1:0] dat_q;
                logic [NODES-1:0]            vld_q;
                logic [SEL_WIDTH-1:0]        sel_q;
                logic                        sv_q;
                logic                        err_q;

                // Reset discards in-flight words; en = 0 freezes the stage
                // and leaves the upstream values unsampled.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        dat_q <= '0;
                        vld_q <= '0;
                        sel_q <= '0;
                        sv_q  <= 1'b0;
                        err_q <= 1'b0;
                    end else if (en) begin
                        dat_q <= dat_d;
                        vld_q <= vld_d;
                        sel_q <= g_lvl[i-1].sel_s;
                        sv_q  <= g_lvl[i-1].sv_s;
                        err_q <= g_lvl[i-1].err_s;
                    end
                end

                assign dat   = dat_q;
                assign vld   = vld_q;
                assign sel_s = sel_q;
                assign sv_s  = sv_q;
                assign err_s = err_q;
            end else begin : g_comb
                assign dat   = dat_d;
                assign vld   = vld_d;
                assign sel_s = g_lvl[i-1].sel_s;
                assign sv_s  = g_lvl[i-1].sv_s;
                assign err_s = g_lvl[i-1].err_s;
            end
        end
    end

    // err forces out_valid low even if the out-of-range path happened to
    // land on a leaf whose valid is set.
    assign out_data  = g_lvl[DEPTH].dat;
    assign out_valid = g_lvl[DEPTH].vld[0] & g_lvl[DEPTH].sv_s & ~g_lvl[DEPTH].err_s;
    assign out_sel   = g_lvl[DEPTH].sel_s;
    assign out_err   = g_lvl[DEPTH].err_s;

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Purpose: directed check of mux_tree_pipe in four configurations sharing one stimulus.
// Latency: checks N=8/5 stride 1 at +3, N=8 stride 2 at +1, N=8 stride 0 at +0.
// Backpressure: exercises en stalls and asynchronous reset with words in flight.
module tb_mux_tree_pipe;

    localparam int W  = 64;
    localparam int NV = 14;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           en;
    logic [8*W-1:0] in_data;
    logic [7:0]     in_valid;
    logic [2:0]     sel;
    logic           sel_valid;

    // a: N=8 stride 1, b: N=5 stride 1, c: N=8 stride 2, d: N=8 stride 0
    logic [W-1:0] d_a, d_b, d_c, d_d;
    logic         v_a, v_b, v_c, v_d;
    logic [2:0]   s_a, s_b, s_c, s_d;
    logic         e_a, e_b, e_c, e_d;

    always #5 clk = ~clk;

    mux_tree_pipe #(.N_INPUTS(8), .DATA_WIDTH(W), .PIPE_STRIDE(1)) u_a (
        .clk(clk), .rst_n(rst_n), .en(en), .in_data(in_data), .in_valid(in_valid),
        .sel(sel), .sel_valid(sel_valid),
        .out_data(d_a), .out_valid(v_a), .out_sel(s_a), .out_err(e_a));

    mux_tree_pipe #(.N_INPUTS(5), .DATA_WIDTH(W), .PIPE_STRIDE(1)) u_b (
        .clk(clk), .rst_n(rst_n), .en(en), .in_data(in_data[5*W-1:0]), .in_valid(in_valid[4:0]),
        .sel(sel), .sel_valid(sel_valid),
        .out_data(d_b), .out_valid(v_b), .out_sel(s_b), .out_err(e_b));

    mux_tree_pipe #(.N_INPUTS(8), .DATA_WIDTH(W), .PIPE_STRIDE(2)) u_c (
        .clk(clk), .rst_n(rst_n), .en(en), .in_data(in_data), .in_valid(in_valid),
        .sel(sel), .sel_valid(sel_valid),
        .out_data(d_c), .out_valid(v_c), .out_sel(s_c), .out_err(e_c));

    mux_tree_pipe #(.N_INPUTS(8), .DATA_WIDTH(W), .PIPE_STRIDE(0)) u_d (
        .clk(clk), .rst_n(rst_n), .en(en), .in_data(in_data), .in_valid(in_valid),
        .sel(sel), .sel_valid(sel_valid),
        .out_data(d_d), .out_valid(v_d), .out_sel(s_d), .out_err(e_d));

    typedef struct {
        logic [2:0]   sel;
        logic         sv;
        logic [7:0]   iv;
        logic [W-1:0] e8_dat;
        logic         e8_vld;
        logic [W-1:0] e5_dat;
        logic         e5_vld;
        logic         e5_err;
    } vec_t;

    vec_t vecs [NV];
    int   n_chk = 0;
    int   n_bad = 0;

    // {data, valid, sel, err}
    function automatic logic [W+4:0] pk(input logic [W-1:0] dat, input logic vld,
                                        input logic [2:0] s, input logic err);
        return {dat, vld, s, err};
    endfunction

    function automatic logic [W+4:0] exp8(input vec_t v);
        return {v.e8_dat, v.e8_vld, v.sel, 1'b0};
    endfunction

    function automatic logic [W+4:0] exp5(input vec_t v);
        return {v.e5_dat, v.e5_vld, v.sel, v.e5_err};
    endfunction

    task automatic chk(input string nm, input int idx, input logic [W+4:0] act, input logic [W+4:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got {dat,vld,sel,err}=%h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        sel       = v.sel;
        sel_valid = v.sv;
        in_valid  = v.iv;
    endtask

    initial begin
        // sel, sv, iv, N8 data/valid, N5 data/valid/err
        vecs[0]  = '{3'd5, 1'b1, 8'hFF, 64'h105, 1'b1, 64'h0,   1'b0, 1'b1};
        vecs[1]  = '{3'd0, 1'b1, 8'hFF, 64'h100, 1'b1, 64'h100, 1'b1, 1'b0};
        vecs[2]  = '{3'd1, 1'b1, 8'hFF, 64'h101, 1'b1, 64'h101, 1'b1, 1'b0};
        vecs[3]  = '{3'd2, 1'b1, 8'hFF, 64'h102, 1'b1, 64'h102, 1'b1, 1'b0};
        vecs[4]  = '{3'd3, 1'b1, 8'hFF, 64'h103, 1'b1, 64'h103, 1'b1, 1'b0};
        vecs[5]  = '{3'd4, 1'b1, 8'hFF, 64'h104, 1'b1, 64'h104, 1'b1, 1'b0};
        vecs[6]  = '{3'd5, 1'b1, 8'hFF, 64'h105, 1'b1, 64'h0,   1'b0, 1'b1};
        vecs[7]  = '{3'd6, 1'b1, 8'hFF, 64'h106, 1'b1, 64'h0,   1'b0, 1'b1};
        vecs[8]  = '{3'd7, 1'b1, 8'hFF, 64'h107, 1'b1, 64'h0,   1'b0, 1'b1};
        vecs[9]  = '{3'd4, 1'b1, 8'hEF, 64'h104, 1'b0, 64'h104, 1'b0, 1'b0};
        vecs[10] = '{3'd3, 1'b0, 8'hFF, 64'h103, 1'b0, 64'h103, 1'b0, 1'b0};
        vecs[11] = '{3'd3, 1'b1, 8'hF7, 64'h103, 1'b0, 64'h103, 1'b0, 1'b0};
        vecs[12] = '{3'd7, 1'b0, 8'hFF, 64'h107, 1'b0, 64'h0,   1'b0, 1'b0};
        vecs[13] = '{3'd2, 1'b1, 8'hFF, 64'h102, 1'b1, 64'h102, 1'b1, 1'b0};

        for (int k = 0; k < 8; k++) in_data[k*W +: W] = 64'h100 + 64'(k);
        rst_n     = 1'b0;
        en        = 1'b1;
        sel       = 3'd0;
        sel_valid = 1'b0;
        in_valid  = 8'h00;

        // Reset state of the registered configurations.
        #2;
        chk("rst_a", 0, pk(d_a, v_a, s_a, e_a), '0);
        chk("rst_b", 0, pk(d_b, v_b, s_b, e_b), '0);
        chk("rst_c", 0, pk(d_c, v_c, s_c, e_c), '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Table stream, one vector per cycle, each DUT checked at its latency.
        for (int s = 0; s < NV + 3; s++) begin
            @(negedge clk);
            if (s >= 3) begin
                chk("tab_n8_l3", s - 3, pk(d_a, v_a, s_a, e_a), exp8(vecs[s-3]));
                chk("tab_n5_l3", s - 3, pk(d_b, v_b, s_b, e_b), exp5(vecs[s-3]));
            end
            if (s >= 1 && s <= NV)
                chk("tab_n8_l1", s - 1, pk(d_c, v_c, s_c, e_c), exp8(vecs[s-1]));
            if (s < NV) begin
                drive(vecs[s]);
                #1;
                chk("tab_n8_l0", s, pk(d_d, v_d, s_d, e_d), exp8(vecs[s]));
            end
        end

        // Stall: stream 1,2,3 then hold en low for 4 edges while sel moves.
        in_valid  = 8'hFF;
        sel_valid = 1'b1;
        @(negedge clk); sel = 3'd1;
        @(negedge clk); sel = 3'd2;
        @(negedge clk); sel = 3'd3;
        @(negedge clk);
        chk("stall_a", 0, pk(d_a, v_a, s_a, e_a), pk(64'h101, 1'b1, 3'd1, 1'b0));
        chk("stall_c", 0, pk(d_c, v_c, s_c, e_c), pk(64'h103, 1'b1, 3'd3, 1'b0));
        en  = 1'b0;
        sel = 3'd6;
        #1;
        chk("stall_d", 0, pk(d_d, v_d, s_d, e_d), pk(64'h106, 1'b1, 3'd6, 1'b0));
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk("stall_a", i, pk(d_a, v_a, s_a, e_a), pk(64'h101, 1'b1, 3'd1, 1'b0));
            chk("stall_c", i, pk(d_c, v_c, s_c, e_c), pk(64'h103, 1'b1, 3'd3, 1'b0));
            sel = 3'(7 - i);
        end
        @(negedge clk);
        chk("stall_a", 4, pk(d_a, v_a, s_a, e_a), pk(64'h101, 1'b1, 3'd1, 1'b0));
        chk("stall_c", 4, pk(d_c, v_c, s_c, e_c), pk(64'h103, 1'b1, 3'd3, 1'b0));
        en  = 1'b1;
        sel = 3'd0;
        @(negedge clk);
        chk("resume_a", 0, pk(d_a, v_a, s_a, e_a), pk(64'h102, 1'b1, 3'd2, 1'b0));
        chk("resume_c", 0, pk(d_c, v_c, s_c, e_c), pk(64'h100, 1'b1, 3'd0, 1'b0));
        sel = 3'd7;
        @(negedge clk);
        chk("resume_a", 1, pk(d_a, v_a, s_a, e_a), pk(64'h103, 1'b1, 3'd3, 1'b0));
        @(negedge clk);
        chk("resume_a", 2, pk(d_a, v_a, s_a, e_a), pk(64'h100, 1'b1, 3'd0, 1'b0));
        sel = 3'd1;
        @(negedge clk);
        chk("resume_a", 3, pk(d_a, v_a, s_a, e_a), pk(64'h107, 1'b1, 3'd7, 1'b0));

        // Reset between edges with three words in flight.
        sel = 3'd2;
        @(negedge clk); sel = 3'd3;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_a", 0, pk(d_a, v_a, s_a, e_a), '0);
        chk("arst_b", 0, pk(d_b, v_b, s_b, e_b), '0);
        chk("arst_c", 0, pk(d_c, v_c, s_c, e_c), '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sel   = 3'd4;
        @(negedge clk);
        chk("post_a", 1, pk(d_a, v_a, s_a, e_a), '0);
        chk("post_c", 1, pk(d_c, v_c, s_c, e_c), pk(64'h104, 1'b1, 3'd4, 1'b0));
        @(negedge clk);
        chk("post_a", 2, pk(d_a, v_a, s_a, e_a), '0);
        chk("post_b", 2, pk(d_b, v_b, s_b, e_b), '0);
        @(negedge clk);
        chk("post_a", 3, pk(d_a, v_a, s_a, e_a), pk(64'h104, 1'b1, 3'd4, 1'b0));
        chk("post_b", 3, pk(d_b, v_b, s_b, e_b), pk(64'h104, 1'b1, 3'd4, 1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end

endmodule
